// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: port identifiers and
// the default bound on consecutive locked loader grants.
package ram_arb_pkg;

    typedef enum logic {
        PORT_CORE   = 1'b0,
        PORT_LOADER = 1'b1
    } port_id_e;

    localparam int MAX_LOCK_DEFAULT = 8;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
module ram_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a single-port synchronous RAM between the core (port 0) and a
// loader (port 1) with round-robin, loader bursts via lock1, and bounded starvation.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int data_width = 32,
    parameter int addr_width = 10,
    parameter int MAX_LOCK   = MAX_LOCK_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic [data_width-1:0] wdata0,
    input  logic [data_width-1:0] wdata1,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [data_width-1:0] rdata,
    output logic [addr_width-1:0] daddr,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic [data_width-1:0] ddata_w,
    input  logic [data_width-1:0] ddata_r
);

    localparam int              CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    port_id_e         last_q, last_d;
    port_id_e         pend_id_q, pend_id_d;
    logic             pend_q, pend_d;
    logic             own1_q, own1_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]       rr_gnt;
    logic             lock_hold;
    logic             at_max;

    ram_arb_rr u_rr (
        .req   ({req1, req0}),
        .last  (last_q),
        .grant (rr_gnt)
    );

    // A lock only persists while the loader owned the RAM on the previous beat.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        at_max    = (lock_cnt_q == CNT_MAX);
        lock_hold = own1_q && lock1 && req1;
        if (RST_n) begin
            if (lock_hold && !(at_max && req0)) begin
                gnt1 = 1'b1;
            end else if (lock_hold) begin
                gnt0 = 1'b1;
            end else begin
                gnt0 = rr_gnt[0];
                gnt1 = rr_gnt[1];
            end
        end
    end

    always_comb begin
        daddr    = gnt1 ? addr1  : addr0;
        ddata_w  = gnt1 ? wdata1 : wdata0;
        MemWrite = (gnt0 && we0)  || (gnt1 && we1);
        MemRead  = (gnt0 && !we0) || (gnt1 && !we1);
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = PORT_CORE;
        end else if (gnt1) begin
            last_d = PORT_LOADER;
        end
        pend_d    = MemRead;
        pend_id_d = pend_id_q;
        if (MemRead) begin
            pend_id_d = gnt1 ? PORT_LOADER : PORT_CORE;
        end
        own1_d     = gnt1;
        lock_cnt_d = '0;
        if (gnt1 && lock1) begin
            lock_cnt_d = at_max ? lock_cnt_q : lock_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            last_q     <= PORT_LOADER;
            pend_q     <= 1'b0;
            pend_id_q  <= PORT_CORE;
            own1_q     <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            pend_q     <= pend_d;
            pend_id_q  <= pend_id_d;
            own1_q     <= own1_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Read data is shared; rvalid steers it to the port whose read was accepted.
    assign rvalid0 = RST_n && pend_q && (pend_id_q == PORT_CORE);
    assign rvalid1 = RST_n && pend_q && (pend_id_q == PORT_LOADER);
    assign rdata   = ddata_r;

endmodule
